// File: rtl/frame_buffer_wr.sv
// Writes inbound frames into a circular BRAM and commits only clean frames; there is no backpressure, so overflow or error frames are dropped and rewound.
// Latency: the BRAM write follows its beat by 1 cycle, and the commit pulse follows the last write by 1 cycle.
module frame_buffer_wr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    input  logic              s_err_i,
    input  logic [ADDR_W-1:0] rd_ptr_i,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              commit_valid_o,
    output logic [ADDR_W-1:0] commit_ptr_o,
    output logic [ADDR_W-1:0] commit_len_o,
    output logic [15:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   frm_start_q, frm_start_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                cmt_pend_q, cmt_pend_d;
    logic [ADDR_W-1:0]   cmt_ptr_pend_q, cmt_ptr_pend_d;
    logic [ADDR_W-1:0]   cmt_len_pend_q, cmt_len_pend_d;
    logic                commit_valid_q, commit_valid_d;
    logic [ADDR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [ADDR_W-1:0]   commit_len_q, commit_len_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0]   used;
    logic                full;
    logic                frame_bad;
    logic                drop_inc;
    logic [ADDR_W-1:0]   wr_ptr_inc;

    // One slot stays empty so wr_ptr == rd_ptr_i always means empty, never full.
    assign used       = wr_ptr_q - rd_ptr_i;
    assign full       = (used == {ADDR_W{1'b1}});
    assign frame_bad  = err_q | s_err_i;
    assign wr_ptr_inc = wr_ptr_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        frm_start_d    = frm_start_q;
        len_d          = len_q;
        err_d          = err_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        wr_addr_d      = wr_addr_q;
        cmt_pend_d     = 1'b0;
        cmt_ptr_pend_d = cmt_ptr_pend_q;
        cmt_len_pend_d = cmt_len_pend_q;
        commit_valid_d = cmt_pend_q;
        commit_ptr_d   = commit_ptr_q;
        commit_len_d   = commit_len_q;
        drop_inc       = 1'b0;

        if (cmt_pend_q) begin
            commit_ptr_d = cmt_ptr_pend_q;
            commit_len_d = cmt_len_pend_q;
        end

        if (s_valid_i) begin
            unique case (state_q)
                ST_IDLE, ST_WRITE: begin
                    if (full) begin
                        // No room: rewind to the frame start and drop the rest of the frame.
                        wr_ptr_d = frm_start_q;
                        len_d    = '0;
                        err_d    = 1'b0;
                        if (s_last_i) begin
                            drop_inc = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_DISCARD;
                        end
                    end else if (s_last_i) begin
                        len_d = '0;
                        err_d = 1'b0;
                        state_d = ST_IDLE;
                        if (frame_bad) begin
                            wr_ptr_d = frm_start_q;
                            drop_inc = 1'b1;
                        end else begin
                            wr_en_d        = 1'b1;
                            wr_data_d      = s_data_i;
                            wr_addr_d      = wr_ptr_q;
                            wr_ptr_d       = wr_ptr_inc;
                            frm_start_d    = wr_ptr_inc;
                            cmt_pend_d     = 1'b1;
                            cmt_ptr_pend_d = wr_ptr_inc;
                            cmt_len_pend_d = len_q + 1'b1;
                        end
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = s_data_i;
                        wr_addr_d = wr_ptr_q;
                        wr_ptr_d  = wr_ptr_inc;
                        len_d     = len_q + 1'b1;
                        err_d     = frame_bad;
                        state_d   = ST_WRITE;
                    end
                end
                ST_DISCARD: begin
                    if (s_last_i) begin
                        drop_inc = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            frm_start_q    <= '0;
            len_q          <= '0;
            err_q          <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_addr_q      <= '0;
            cmt_pend_q     <= 1'b0;
            cmt_ptr_pend_q <= '0;
            cmt_len_pend_q <= '0;
            commit_valid_q <= 1'b0;
            commit_ptr_q   <= '0;
            commit_len_q   <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            frm_start_q    <= frm_start_d;
            len_q          <= len_d;
            err_q          <= err_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_addr_q      <= wr_addr_d;
            cmt_pend_q     <= cmt_pend_d;
            cmt_ptr_pend_q <= cmt_ptr_pend_d;
            cmt_len_pend_q <= cmt_len_pend_d;
            commit_valid_q <= commit_valid_d;
            commit_ptr_q   <= commit_ptr_d;
            commit_len_q   <= commit_len_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_data_o      = wr_data_q;
    assign wr_addr_o      = wr_addr_q;
    assign commit_valid_o = commit_valid_q;
    assign commit_ptr_o   = commit_ptr_q;
    assign commit_len_o   = commit_len_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_wr.sv
// Scoreboard bench for frame_buffer_wr with a 16-word buffer; expectations come from a frame-level space/error model.
module tb_frame_buffer_wr;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_err_i = 1'b0;
    logic [AW-1:0] rd_ptr_i = '0;
    logic          wr_en_o;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] wr_addr_o;
    logic          commit_valid_o;
    logic [AW-1:0] commit_ptr_o;
    logic [AW-1:0] commit_len_o;
    logic [15:0]   drop_cnt_o;

    frame_buffer_wr #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid_i      (s_valid_i),
        .s_data_i       (s_data_i),
        .s_last_i       (s_last_i),
        .s_err_i        (s_err_i),
        .rd_ptr_i       (rd_ptr_i),
        .wr_en_o        (wr_en_o),
        .wr_data_o      (wr_data_o),
        .wr_addr_o      (wr_addr_o),
        .commit_valid_o (commit_valid_o),
        .commit_ptr_o   (commit_ptr_o),
        .commit_len_o   (commit_len_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] ptr;
        logic [AW-1:0] len;
    } cm_t;

    wr_t wq[$];
    cm_t cq[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] m_start = '0;
    logic [15:0]   m_drop  = '0;
    logic [AW-1:0] m_cptr  = '0;
    logic [AW-1:0] m_clen  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write and commit the DUT emits must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
                    chk("wr_data", 32'(wr_data_o), 32'(e.data));
                end
            end
            if (commit_valid_o) begin
                if (cq.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    cm_t c;
                    c = cq.pop_front();
                    chk("commit_ptr", 32'(commit_ptr_o), 32'(c.ptr));
                    chk("commit_len", 32'(commit_len_o), 32'(c.len));
                end
            end
        end
    end

    // Frame-level model: a frame fits when its length does not exceed the free space
    // (one slot always kept empty); an errored frame writes all but its last beat.
    task automatic send_frame(input int n, input int err_idx, input logic [DW-1:0] base);
        logic [AW-1:0] free_w;
        int  free;
        int  nwr;
        bit  good;
        free_w = rd_ptr_i - m_start - 4'd1;
        free   = int'(free_w);
        if (n > free) begin
            nwr  = free;
            good = 1'b0;
        end else if (err_idx >= 0) begin
            nwr  = n - 1;
            good = 1'b0;
        end else begin
            nwr  = n;
            good = 1'b1;
        end
        for (int i = 0; i < nwr; i++) begin
            wq.push_back('{addr: m_start + AW'(i), data: base + DW'(i)});
        end
        if (good) begin
            m_start = m_start + AW'(n);
            m_cptr  = m_start;
            m_clen  = AW'(n);
            cq.push_back('{ptr: m_cptr, len: m_clen});
        end else if (m_drop != 16'hFFFF) begin
            m_drop = m_drop + 16'd1;
        end
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = base + DW'(i);
            s_last_i  = (i == n - 1);
            s_err_i   = (i == err_idx);
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        s_err_i   = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'(m_drop));
        chk({tag, "_writes_left"}, 32'(wq.size()), 32'd0);
        chk({tag, "_commits_left"}, 32'(cq.size()), 32'd0);
        chk({tag, "_commit_ptr_hold"}, 32'(commit_ptr_o), 32'(m_cptr));
        chk({tag, "_commit_len_hold"}, 32'(commit_len_o), 32'(m_clen));
        wq.delete();
        cq.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data_o), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
        chk({tag, "_commit_valid"}, 32'(commit_valid_o), 32'd0);
        chk({tag, "_commit_ptr"}, 32'(commit_ptr_o), 32'd0);
        chk({tag, "_commit_len"}, 32'(commit_len_o), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic good frame from address 0.
        send_frame(4, -1, 8'hA0);
        drain("good4");

        // Error on the middle beat: two words written then rewound.
        send_frame(3, 1, 8'hB0);
        drain("err3");
        send_frame(2, -1, 8'hC0);
        drain("after_err");

        // Reset in the middle of a frame.
        wq.push_back('{addr: m_start, data: 8'h70});
        wq.push_back('{addr: m_start + 4'd1, data: 8'h71});
        s_valid_i = 1'b1;
        s_data_i  = 8'h70;
        @(posedge clk);
        #1;
        s_data_i  = 8'h71;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midframe_rst");
        chk("midframe_writes_seen", 32'(wq.size()), 32'd0);
        wq.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        m_start = '0;
        m_drop  = '0;
        m_cptr  = '0;
        m_clen  = '0;
        @(posedge clk);
        #1;

        // Overflow: 15 words fit, the rest is discarded.
        rd_ptr_i = 4'd0;
        send_frame(20, -1, 8'h10);
        drain("overflow");
        send_frame(14, -1, 8'h40);
        drain("refill");

        // Wrap across the top of the buffer.
        rd_ptr_i = 4'd14;
        send_frame(4, -1, 8'h60);
        drain("wrap");

        // Last beat meets a full buffer, then an exact fit, then zero space.
        rd_ptr_i = 4'd5;
        send_frame(3, -1, 8'h80);
        drain("full_on_last");
        send_frame(2, -1, 8'h88);
        drain("exact_fit");
        send_frame(1, -1, 8'h8C);
        drain("no_space");

        // Back-to-back frames with no idle cycle between them.
        rd_ptr_i = 4'd4;
        send_frame(1, -1, 8'h90);
        send_frame(3, 2, 8'h94);
        send_frame(2, -1, 8'h98);
        send_frame(1, 0, 8'h9C);
        send_frame(4, -1, 8'hC4);
        send_frame(1, -1, 8'hD0);
        drain("b2b");

        // Saturate the drop counter.
        repeat (65536) send_frame(1, 0, 8'hEE);
        drain("saturate");
        send_frame(1, 0, 8'hEF);
        drain("saturate_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer_wr.md
FRAME_BUFFER_WR -- requirements
Module: frame_buffer_wr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning stream beat width and BRAM word width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning BRAM address width (DEPTH = 2**ADDR_W).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid_i  input  1  inbound beat valid; no backpressure exists.
REQ-006 SHALL have port s_data_i  input  DATA_W  inbound beat data.
REQ-007 SHALL have port s_last_i  input  1  final beat of frame.
REQ-008 SHALL have port s_err_i  input  1  beat carries error (bad FCS/PHY error); valid on any beat.
REQ-009 SHALL have port rd_ptr_i  input  ADDR_W  consumer's next read address; words below it are free.
REQ-010 SHALL have port wr_en_o  output  1  BRAM write enable.
REQ-011 SHALL have port wr_data_o  output  DATA_W  BRAM write data.
REQ-012 SHALL have port wr_addr_o  output  ADDR_W  BRAM write address.
REQ-013 SHALL have port commit_valid_o  output  1  one-cycle pulse: frame committed.
REQ-014 SHALL have port commit_ptr_o  output  ADDR_W  address one past the committed frame's last word.
REQ-015 SHALL have port commit_len_o  output  ADDR_W  committed frame length in beats.
REQ-016 SHALL have port drop_cnt_o  output  16  dropped-frame count, saturating at 16'hFFFF.

Function
REQ-017 SHALL keep wr_ptr (next write address), frm_start (first address of open frame), frame length counter, sticky error flag.
REQ-018 SHALL compute used = (wr_ptr - rd_ptr_i) mod DEPTH and full = (used == DEPTH-1).
REQ-019 SHALL implement states IDLE, WRITE, DISCARD.
REQ-020 SHALL, in IDLE/WRITE on accepted beat with !full, register wr_en_o=1, wr_data_o=s_data_i, wr_addr_o=wr_ptr, and increment wr_ptr (wrapping DEPTH-1 -> 0); IDLE -> WRITE on a non-last beat.
REQ-021 SHALL drive wr_en_o low in any cycle with no qualifying write; BRAM outputs have 1-cycle latency from s_valid_i.
REQ-022 SHALL set the sticky error flag on any beat with s_err_i=1 during the frame.
REQ-023 SHALL, on last beat with !full and no error (sticky or current), write it and pulse commit_valid_o one cycle after that beat's wr_en_o, with commit_ptr_o = wr_ptr+1 and commit_len_o = frame length including last beat; frm_start <= wr_ptr+1; -> IDLE.
REQ-024 SHALL, on last beat with error, not write it, restore wr_ptr <= frm_start, increment drop_cnt_o, no commit; -> IDLE.
REQ-025 SHALL, on a beat arriving while full, not write, restore wr_ptr <= frm_start; if last, increment drop_cnt_o and -> IDLE, else -> DISCARD.
REQ-026 SHALL, in DISCARD, ignore all beats without writing; on last beat increment drop_cnt_o and -> IDLE.
REQ-027 SHALL treat a single-beat frame (s_last_i on first beat) as complete frame of length 1.
REQ-028 SHALL hold commit_ptr_o and commit_len_o stable between commit pulses.
REQ-029 SHALL never write an address in [rd_ptr_i, frm_start) mod DEPTH.
REQ-030 SHALL count commits and drops for back-to-back frames with no idle cycle between last and next first beat.

Reset
REQ-031 SHALL, while rst=1, asynchronously force state IDLE, wr_ptr=0, frm_start=0, length=0, error flag=0, and outputs wr_en_o=0, wr_data_o=0, wr_addr_o=0, commit_valid_o=0, commit_ptr_o=0, commit_len_o=0, drop_cnt_o=0.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no commit and no drop count; first beat after release starts a new frame at address 0.

Verification (ADDR_W=4, DEPTH=16)
REQ-033 SHALL verify: 4-beat frame 0xA0..0xA3, rd_ptr_i=0 -> writes addr 0..3, commit_valid_o pulse, commit_ptr_o=4, commit_len_o=4.
REQ-034 SHALL verify: 3-beat frame with s_err_i on beat 2 after REQ-033 -> addr 4..5 written, wr_ptr back to 4, drop_cnt_o=1, no commit; next frame writes from addr 4.
REQ-035 SHALL verify: rd_ptr_i=0, 20-beat frame -> 15 writes (addr 0..14), then DISCARD, drop_cnt_o=1, wr_ptr=0, no commit.
REQ-036 SHALL verify wrap: rd_ptr_i=14, wr_ptr=14, 4-beat good frame -> addr 14,15,0,1, commit_ptr_o=2, commit_len_o=4.
REQ-037 SHALL verify: rst asserted after 2 beats of frame -> all outputs 0 asynchronously, no commit_valid_o pulse, drop_cnt_o=0.
REQ-038 SHALL verify: drop_cnt_o preset near 16'hFFFF via 65536 dropped 1-beat frames -> holds at 16'hFFFF.
